// File: rtl/packet_rr_arbiter.sv
// packet_rr_arbiter: round-robin arbiter that locks one input stream per packet into a registered output stage.
module packet_rr_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH_INPUTS = 8,
    localparam int WIDTH_SELECT = $clog2(NUM_INPUTS)
) (
    input  logic clk,
    input  logic rst,
    input  logic [NUM_INPUTS-1:0][WIDTH_INPUTS-1:0] in_data,
    input  logic [NUM_INPUTS-1:0] in_valid,
    input  logic [NUM_INPUTS-1:0] in_last,
    output logic [NUM_INPUTS-1:0] in_ready,
    output logic [WIDTH_INPUTS-1:0] out_data,
    output logic out_valid,
    output logic out_last,
    input  logic out_ready,
    output logic [WIDTH_SELECT-1:0] grant_sel,
    output logic busy
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    logic [0:0] state;
    logic [WIDTH_SELECT-1:0] last_grant, next_grant, cand;
    logic can_load, in_xfer;
    assign busy = state == LOCKED;
    assign can_load = !out_valid || out_ready;
    assign in_ready = (busy && can_load) ? NUM_INPUTS'(1) << grant_sel : '0;
    assign in_xfer = busy && can_load && in_valid[grant_sel];
    // Scan from farthest to nearest offset so the nearest requester after last_grant wins.
    always_comb begin
        next_grant = grant_sel;
        cand = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            cand = WIDTH_SELECT'((int'(last_grant) + k) % NUM_INPUTS);
            if (in_valid[cand]) next_grant = cand;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant_sel <= '0;
            last_grant <= WIDTH_SELECT'(NUM_INPUTS - 1);
            out_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            if (in_xfer) begin
                out_data <= in_data[grant_sel];
                out_last <= in_last[grant_sel];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (state == IDLE && |in_valid) begin
                grant_sel <= next_grant;
                state <= LOCKED;
            end else if (in_xfer && in_last[grant_sel]) begin
                last_grant <= grant_sel;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_packet_rr_arbiter.sv
// tb_packet_rr_arbiter: directed stimulus with a queue scoreboard on the output stream.
module tb_packet_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0][7:0] in_data = '0;
    logic [3:0] in_valid = '0, in_last = '0, in_ready;
    logic [7:0] out_data;
    logic out_valid, out_last;
    logic out_ready = 1'b1;
    logic [1:0] grant_sel;
    logic busy;
    logic [2:0][7:0] d3 = '0;
    logic [2:0] v3 = '0, l3 = '0, r3;
    logic [7:0] od3;
    logic ov3, ol3, b3;
    logic [1:0] g3;
    logic [8:0] q[$];
    int checks = 0, fails = 0;
    int e3[4] = '{0, 2, 0, 2};
    always #5 clk = ~clk;

    packet_rr_arbiter #(.NUM_INPUTS(4), .WIDTH_INPUTS(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .grant_sel(grant_sel), .busy(busy));

    packet_rr_arbiter #(.NUM_INPUTS(3), .WIDTH_INPUTS(8)) dut3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_last(l3),
        .in_ready(r3), .out_data(od3), .out_valid(ov3), .out_last(ol3),
        .out_ready(1'b1), .grant_sel(g3), .busy(b3));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send_beat(input int p, input logic [7:0] d, input logic l);
        logic acc;
        acc = 1'b0;
        in_data[p] = d;
        in_last[p] = l;
        in_valid[p] = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            #1 acc = in_ready[p];
            @(posedge clk);
            @(negedge clk);
        end
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: port %0d beat %0h never accepted", p, d);
        end
        if (l) in_valid[p] = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        #4;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: got %0h expected no beat", {out_last, out_data});
            end else begin
                e = q.pop_front();
                if ({out_last, out_data} !== e) begin
                    fails++;
                    $display("FAIL sb_beat: got %0h expected %0h", {out_last, out_data}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hd;
        logic hl;
        int t;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("idle_out_valid", out_valid, 0);
            chk("idle_in_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
            chk("idle_grant", grant_sel, 0);
        end
        // Three-beat packet from port 2.
        q.push_back({1'b0, 8'hA1});
        q.push_back({1'b0, 8'hA2});
        q.push_back({1'b1, 8'hA3});
        in_data[2] = 8'hA1;
        in_valid[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("p2_busy", busy, 1);
        chk("p2_grant", grant_sel, 2);
        chk("p2_in_ready", in_ready, 4'b0100);
        send_beat(2, 8'hA1, 1'b0);
        #1 chk("p2_out_valid", out_valid, 1);
        send_beat(2, 8'hA2, 1'b0);
        send_beat(2, 8'hA3, 1'b1);
        #1 chk("p2_busy_done", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // All four ports request continuously: two single-beat packets each.
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++) q.push_back({1'b1, 4'(p), 4'(k)});
        fork
            begin send_beat(0, 8'h00, 1'b1); send_beat(0, 8'h01, 1'b1); end
            begin send_beat(1, 8'h10, 1'b1); send_beat(1, 8'h11, 1'b1); end
            begin send_beat(2, 8'h20, 1'b1); send_beat(2, 8'h21, 1'b1); end
            begin send_beat(3, 8'h30, 1'b1); send_beat(3, 8'h31, 1'b1); end
            begin
                for (int i = 0; i < 8; i++) begin
                    t = 0;
                    #2;
                    while (!busy && t < 20) begin @(negedge clk); #2; t++; end
                    chk("rr_busy", busy, 1);
                    chk("rr_grant", grant_sel, i % 4);
                    @(negedge clk);
                    #2 chk("rr_bubble", busy, 0);
                    @(negedge clk);
                end
            end
        join
        // Three-input arbiter: ports 0 and 2 requesting, port 2 was last granted by reset.
        @(negedge clk);
        l3 = 3'b111;
        v3 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            #2;
            while (!b3 && t < 20) begin @(negedge clk); #2; t++; end
            chk("n3_busy", b3, 1);
            chk("n3_grant", g3, e3[i]);
            @(negedge clk);
        end
        v3 = 3'b000;
        // Backpressure mid-packet from port 1.
        @(negedge clk);
        for (int i = 1; i <= 4; i++) q.push_back({i == 4, 8'hB0 + 8'(i)});
        fork
            begin
                send_beat(1, 8'hB1, 1'b0);
                send_beat(1, 8'hB2, 1'b0);
                send_beat(1, 8'hB3, 1'b0);
                send_beat(1, 8'hB4, 1'b1);
            end
            begin
                t = 0;
                while (!out_valid && t < 50) begin @(negedge clk); t++; end
                out_ready = 1'b0;
                hd = out_data;
                hl = out_last;
                chk("bp_first_data", hd, 8'hB1);
                for (int i = 0; i < 5; i++) begin
                    #2;
                    chk("bp_data_stable", out_data, hd);
                    chk("bp_last_stable", out_last, hl);
                    chk("bp_in_ready", in_ready, 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        // Reset on the second beat of a port-1 packet while the first is still held.
        @(negedge clk);
        send_beat(1, 8'h11, 1'b0);
        out_ready = 1'b0;
        in_data[1] = 8'h12;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_grant", grant_sel, 0);
        rst = 1'b0;
        in_valid[1] = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        q.push_back({1'b1, 8'h0F});
        q.push_back({1'b1, 8'h1F});
        in_data[0] = 8'h0F;
        in_last[0] = 1'b1;
        in_valid[0] = 1'b1;
        in_data[1] = 8'h1F;
        in_last[1] = 1'b1;
        in_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rearb_grant", grant_sel, 0);
        chk("rearb_busy", busy, 1);
        fork
            send_beat(0, 8'h0F, 1'b1);
            send_beat(1, 8'h1F, 1'b1);
        join
        repeat (5) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
